// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, issues one icache read per cycle,
// and buffers {instruction, PC} pairs in a small FIFO toward decode.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_BOOT | one idle cycle after reset so the icache can finish its init
// ST_RUN  | normal fetching, one request per cycle while there is room
// ST_HALT | fetching stopped; FIFO keeps draining; only a redirect exits
module ifetch #(
    parameter int                  AWIDTH          = 32,
    parameter int                  DWIDTH          = 32,
    parameter logic [AWIDTH-1:0]   RESET_PC        = '0,
    parameter int                  LOG2_FIFO_DEPTH = 1,
    parameter int                  FIFO_DEPTH      = 1 << LOG2_FIFO_DEPTH
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    output logic                       o_mem_rq,
    output logic                       o_rnw,
    output logic [AWIDTH-1:0]          o_pc,
    input  logic [DWIDTH-1:0]          i_inst,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [DWIDTH-1:0]          o_inst,
    output logic [AWIDTH-1:0]          o_inst_pc,
    input  logic                       i_redirect,
    input  logic [AWIDTH-1:0]          i_redirect_pc,
    input  logic                       i_halt,
    output logic [LOG2_FIFO_DEPTH:0]   o_count
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Fetch addresses are always word aligned.
    localparam logic [AWIDTH-1:0]          PC_MASK  = ~(AWIDTH'(3));
    localparam logic [AWIDTH-1:0]          PC_STEP  = AWIDTH'(4);
    localparam logic [LOG2_FIFO_DEPTH:0]   FULL_CNT = (LOG2_FIFO_DEPTH + 1)'(FIFO_DEPTH);
    localparam logic [LOG2_FIFO_DEPTH:0]   CNT_ONE  = (LOG2_FIFO_DEPTH + 1)'(1);
    localparam logic [LOG2_FIFO_DEPTH-1:0] PTR_ONE  = (LOG2_FIFO_DEPTH)'(1);

    state_t                      state;
    logic [AWIDTH-1:0]           pc;
    logic [LOG2_FIFO_DEPTH-1:0]  wr_ptr;
    logic [LOG2_FIFO_DEPTH-1:0]  rd_ptr;
    logic [LOG2_FIFO_DEPTH:0]    count;
    logic [DWIDTH-1:0]           inst_q [FIFO_DEPTH];
    logic [AWIDTH-1:0]           pc_q   [FIFO_DEPTH];
    logic                        full;
    logic                        pop;
    logic                        push;

    // Handshake and request decode; a pop frees a slot in the same cycle.
    always_comb begin
        full     = (count == FULL_CNT);
        pop      = (count != '0) & i_ready;
        push     = (state == ST_RUN) & ~i_redirect & (~full | pop);
        o_mem_rq = push;
        o_rnw    = 1'b1;
        o_pc     = pc;
        o_valid  = (count != '0);
        o_count  = count;
        o_inst   = inst_q[rd_ptr];
        o_inst_pc = pc_q[rd_ptr];
    end

    // FSM, PC and FIFO bookkeeping; redirect flushes and wins over push/pop.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state  <= ST_BOOT;
            pc     <= RESET_PC & PC_MASK;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_redirect) begin
            state  <= ST_RUN;
            pc     <= i_redirect_pc & PC_MASK;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            case (state)
                ST_BOOT: state <= ST_RUN;
                ST_RUN:  if (i_halt) state <= ST_HALT;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_BOOT;
            endcase
            if (push) begin
                pc     <= pc + PC_STEP;
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push & ~pop) begin
                count <= count + CNT_ONE;
            end else if (pop & ~push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // FIFO storage is deliberately not reset; only pointers and count are.
    always_ff @(posedge i_clk) begin
        if (push & i_reset_n) begin
            inst_q[wr_ptr] <= i_inst;
            pc_q[wr_ptr]   <= pc;
        end
    end

endmodule
